// File: rtl/proc_pkg.sv
// ============================================================================
//  proc_pkg : shared branch codes, default widths and the EX/MEM beat record
//  Revision : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLTZ = 3'b011,
    BR_BGEZ = 3'b100,
    BR_BLEZ = 3'b101,
    BR_BGTZ = 3'b110,
    BR_J    = 3'b111
  } br_op_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } beat_t;

endpackage

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
//  branch_resolve : combinational branch condition and redirect target
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_resolve #(
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int BR_SHIFT = 2
) (
  input  logic [2:0]        br_op,
  input  logic              zout,
  input  logic              nout,
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-1:0] imm,
  output logic              taken,
  output logic [DATA_W-1:0] target
);
  import proc_pkg::*;

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_NONE: taken = 1'b0;
      BR_BEQ:  taken = zout;
      BR_BNE:  taken = ~zout;
      BR_BLTZ: taken = nout;
      BR_BGEZ: taken = ~nout;
      BR_BLEZ: taken = zout | nout;
      BR_BGTZ: taken = ~zout & ~nout;
      BR_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Carry out of the top bit is dropped: the target wraps modulo 2^DATA_W.
  assign target = pc4 + (imm << BR_SHIFT);

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
//  ex_mem_stage : EX->MEM pipeline register with 2-entry skid buffer and
//                 registered branch redirect
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int REG_AW   = proc_pkg::REG_AW,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_sum,
  input  logic              ex_zout,
  input  logic              ex_nout,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [2:0]        ex_br_op,
  input  logic [DATA_W-1:0] ex_pc4,
  input  logic [DATA_W-1:0] ex_imm,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);
  import proc_pkg::*;

  // State bits are {skid_valid, main_valid}; 2'b10 is unreachable.
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  logic [1:0]        state, state_nx;
  beat_t             main_q, skid_q, ex_beat;
  logic              accept, store, handshake;
  logic              load_main_ex, load_main_skid, load_skid;
  logic              br_hit;
  logic [DATA_W-1:0] br_addr;

  branch_resolve #(
    .DATA_W  (DATA_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_branch_resolve (
    .br_op (ex_br_op),
    .zout  (ex_zout),
    .nout  (ex_nout),
    .pc4   (ex_pc4),
    .imm   (ex_imm),
    .taken (br_hit),
    .target(br_addr)
  );

  assign ex_beat = '{sum: ex_sum, wdata: ex_wdata, rd: ex_rd, regwrite: ex_regwrite,
                     memread: ex_memread, memwrite: ex_memwrite};

  // Beats accepted in a redirect shadow or a flush cycle are consumed but never stored.
  assign accept    = ex_valid & ex_ready;
  assign store     = accept & ~br_taken & ~flush;
  assign handshake = state[0] & mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (store) state_nx = S_ONE;
        S_ONE: begin
          if (store && !handshake)      state_nx = S_FULL;
          else if (!store && handshake) state_nx = S_EMPTY;
        end
        S_FULL:  if (handshake) state_nx = S_ONE;
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_ex   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: load_main_ex = store;
      S_ONE: begin
        load_main_ex = store & handshake;
        load_skid    = store & ~handshake;
      end
      S_FULL:  load_main_skid = handshake;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_ex)        main_q <= ex_beat;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= ex_beat;
    end
  end

  // ex_ready comes straight from a flop so MEM back-pressure never reaches EX combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ready  <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      ex_ready  <= ~state_nx[1];
      br_taken  <= store & br_hit;
      br_target <= (store & br_hit) ? br_addr : '0;
    end
  end

  assign mem_valid      = state[0];
  assign mem_alu_result = main_q.sum;
  assign mem_wdata      = main_q.wdata;
  assign mem_rd         = main_q.rd;
  assign mem_regwrite   = main_q.regwrite;
  assign mem_memread    = main_q.memread;
  assign mem_memwrite   = main_q.memwrite;

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the 32-bit ALU: captures ALU result `sum`, zero flag (zout), negative flag (nout), store data and control bits from EX, and presents them to the MEM stage.
- Registered valid/ready handshake with a 2-entry skid buffer, so MEM back-pressure never creates a combinational ready path into EX.
- Resolves conditional branches from zout/nout and issues a registered one-cycle redirect (br_taken, br_target) to fetch.

Parameters:
- DATA_W, 32, datapath width (sum, store data, PC)
- REG_AW, 5, destination register address width
- BR_SHIFT, 2, left shift applied to the sign-extended immediate for the branch offset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all buffered beats
- ex_valid  in  1  EX beat present
- ex_ready  out  1  stage can accept; registered, equals ~skid_valid
- ex_sum  in  DATA_W  ALU result
- ex_zout  in  1  ALU zero flag
- ex_nout  in  1  ALU negative flag (sum[31])
- ex_wdata  in  DATA_W  store data (rt value)
- ex_rd  in  REG_AW  destination register
- ex_regwrite, ex_memread, ex_memwrite  in  1 each  control bits
- ex_br_op  in  3  branch condition code
- ex_pc4  in  DATA_W  PC+4 of the EX instruction
- ex_imm  in  DATA_W  sign-extended immediate
- mem_valid  out  1  MEM beat present
- mem_ready  in  1  MEM accepts
- mem_alu_result, mem_wdata  out  DATA_W  captured sum / store data
- mem_rd  out  REG_AW;  mem_regwrite, mem_memread, mem_memwrite  out  1 each
- br_taken  out  1  one-cycle redirect pulse
- br_target  out  DATA_W  redirect address; valid only while br_taken = 1

Behaviour:
- Reset (async): all outputs and internal state are 0. ex_ready is therefore 0 during reset and goes to 1 on the first clock edge after reset deasserts.
- Accept: a beat is accepted when ex_valid & ex_ready. Handshake on MEM side: mem_valid & mem_ready.
- Storage: main register (drives mem_*) plus skid register.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY: accept goes to ONE.
  - ONE:
    - accept & handshake: main is replaced; stay in ONE.
    - accept & ~handshake: beat goes to skid; move to FULL.
    - handshake only: move to EMPTY.
  - FULL: ex_ready = 0. On handshake, skid moves into main; move to ONE.
- Latency and throughput: an accepted beat appears on mem_* the next cycle when the stage was EMPTY, or was ONE with a handshake. Sustained throughput is 1 beat per cycle.
- mem_* outputs are stable while mem_valid & ~mem_ready.
- Branch condition (evaluated on the accepted beat), taken when:
  - 000 none: never
  - 001 BEQ: zout
  - 010 BNE: ~zout
  - 011 BLTZ: nout
  - 100 BGEZ: ~nout
  - 101 BLEZ: zout | nout
  - 110 BGTZ: ~zout & ~nout
  - 111 J: always
- Branch redirect:
  - If taken, br_taken = 1 for exactly the next cycle.
  - br_target = ex_pc4 + (ex_imm << BR_SHIFT), modulo 2^DATA_W (wrap-around ignored).
  - The branch beat itself still enters the buffer.
- Shadow drop: in the cycle br_taken = 1, any beat presented with ex_valid & ex_ready is consumed and discarded. It is not stored and raises no branch.
- flush:
  - Priority over everything. Next cycle is EMPTY, mem_valid = 0, br_taken = 0.
  - A beat accepted in the flush cycle is discarded.
  - A pending br_taken from a prior branch still fires if it was registered before the flush edge.
- Reset mid-operation: all beats and any pending redirect are lost immediately.
- Control bits and ex_rd are captured as given; no qualification by branch outcome.

Decomposition:
- Shared package `proc_pkg`:
  - BR_NONE..BR_J branch codes
  - DATA_W and REG_AW defaults
  - packed beat struct {sum, wdata, rd, regwrite, memread, memwrite}
- One sub-module, `branch_resolve`: combinational condition and target calculation. It is instantiated on the EX input side; its outputs are registered in ex_mem_stage.

Test Plan:
- Stream: ex_sum = 1, 2, 3, 4 on consecutive cycles, mem_ready = 1 -> mem_alu_result = 1, 2, 3, 4 one cycle later, mem_valid continuous, ex_ready never 0.
- Back-pressure: 3 beats (0xA, 0xB, 0xC), mem_ready = 0 for 3 cycles then 1 -> ex_ready drops after 0xB is buffered, 0xC is held at EX, output order is 0xA, 0xB, 0xC with none lost or duplicated.
- BEQ taken: ex_br_op = 001, ex_zout = 1, ex_pc4 = 0x100, ex_imm = 0xFFFFFFFF -> next cycle br_taken = 1, br_target = 0xFC. The beat presented in that cycle is dropped.
- BGTZ not taken: ex_br_op = 110, nout = 0, zout = 1 -> br_taken stays 0 and the next beat is accepted normally.
- flush in FULL state with ex_valid = 1 -> next cycle mem_valid = 0, ex_ready = 1, no stale beat emerges afterwards.
- Reset asserted mid-stream, asynchronously -> mem_valid, br_taken and ex_ready are 0 immediately. After release, ex_ready = 1 one edge later.
